// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg: shared constants, FSM encoding and counter sizing for the push-button debouncer
package pb_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } pb_state_t;

    // Wide enough to hold DEBOUNCE_CYCLES without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pb_debounce_channel.sv
// pb_debounce_channel: synchronise, confirm and pulse one normalised button bit
module pb_debounce_channel
    import pb_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [CW-1:0] cnt_q, cnt_d;
    pb_state_t     state_q, state_d;
    logic          diff, accept;

    // A candidate is accepted once it has differed from the level for DEBOUNCE_CYCLES edges.
    always_comb begin
        diff      = s2_q != level_q;
        accept    = diff && (state_q == STABLE ? (DEBOUNCE_CYCLES == 1)
                                               : (cnt_q == CW'(DEBOUNCE_CYCLES - 1)));
        state_d   = (!diff || accept) ? STABLE : CONFIRM;
        cnt_d     = (!diff || accept) ? '0 : (state_q == STABLE ? CW'(1) : cnt_q + CW'(1));
        level_d   = accept ? s2_q : level_q;
        press_d   = accept && s2_q;
        release_d = accept && !s2_q;
    end

    // Two-flop synchroniser feeding the confirmation FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= STABLE;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/push_button_debouncer.sv
// push_button_debouncer: per-channel synchronisation and bounce filtering of raw button pads
module push_button_debouncer
    import pb_debounce_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    // Inversion happens before synchronisation so every channel sees 1 = pressed.
    logic [NUM_BUTTONS-1:0] btn_n;
    assign btn_n = btn_raw ^ {NUM_BUTTONS{ACTIVE_LOW}};

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        pb_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_i    (btn_n[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g])
        );
    end

endmodule
